// File: rtl/guess_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : guess_scoreboard_if
// Brief    : Control strobes into, and score/status outputs out of, the
//            guessing-game scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface guess_scoreboard_if #(
    parameter int SW = 4
);
    logic          start;
    logic          round_valid;
    logic [1:0]    correct_gues;
    logic [1:0]    cr_pair;
    logic [SW-1:0] score1;
    logic [SW-1:0] score2;
    logic [2:0]    round_cnt;
    logic          busy;
    logic          done;
    logic          done_pulse;
    logic [1:0]    winner;
    logic          early_win;

    modport master (
        output start, round_valid, correct_gues, cr_pair,
        input  score1, score2, round_cnt, busy, done, done_pulse, winner, early_win
    );

    modport slave (
        input  start, round_valid, correct_gues, cr_pair,
        output score1, score2, round_cnt, busy, done, done_pulse, winner, early_win
    );
endinterface
`default_nettype wire

// File: rtl/guess_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : guess_scoreboard
// Brief    : Two-player round scoreboard with exact-match early finish and
//            saturating scores; IDLE -> PLAY -> DONE with registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module guess_scoreboard #(
    parameter int ROUNDS = 5,
    parameter int SW     = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    guess_scoreboard_if.slave  gs_if
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SW-1:0] C_SMAX   = {SW{1'b1}};
    localparam logic [2:0]    C_ROUNDS = 3'(ROUNDS);

    state_t        state_q;
    logic [SW-1:0] score1_q;
    logic [SW-1:0] score2_q;
    logic [2:0]    round_cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          done_pulse_q;
    logic [1:0]    winner_q;
    logic          early_win_q;

    logic [SW-1:0] score1_d;
    logic [SW-1:0] score2_d;
    logic [2:0]    round_cnt_d;
    logic [1:0]    inc1_w;
    logic [1:0]    inc2_w;
    logic          exact_w;

    // Sum is computed two bits wider so the +2 of an exact match can be clamped.
    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [1:0] inc);
        logic [SW+1:0] sum;
        sum = {2'b00, a} + {{SW{1'b0}}, inc};
        if (sum > {2'b00, C_SMAX}) begin
            return C_SMAX;
        end
        return sum[SW-1:0];
    endfunction

    always_comb begin
        exact_w = (gs_if.correct_gues != 2'b00);
        inc1_w  = 2'd0;
        inc2_w  = 2'd0;
        if (exact_w) begin
            inc1_w = gs_if.correct_gues[0] ? 2'd2 : 2'd0;
            inc2_w = gs_if.correct_gues[1] ? 2'd2 : 2'd0;
        end else begin
            inc1_w = {1'b0, gs_if.cr_pair[0]};
            inc2_w = {1'b0, gs_if.cr_pair[1]};
        end
        score1_d    = sat_add(score1_q, inc1_w);
        score2_d    = sat_add(score2_q, inc2_w);
        round_cnt_d = round_cnt_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            score1_q     <= '0;
            score2_q     <= '0;
            round_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            winner_q     <= 2'b00;
            early_win_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_pulse_q <= 1'b0;
                    if (gs_if.start) begin
                        state_q     <= S_PLAY;
                        score1_q    <= '0;
                        score2_q    <= '0;
                        round_cnt_q <= '0;
                        winner_q    <= 2'b00;
                        early_win_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (gs_if.round_valid) begin
                        score1_q    <= score1_d;
                        score2_q    <= score2_d;
                        round_cnt_q <= round_cnt_d;
                        if (exact_w || (round_cnt_d == C_ROUNDS)) begin
                            state_q      <= S_DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            done_pulse_q <= 1'b1;
                        end
                        if (exact_w) begin
                            winner_q    <= gs_if.correct_gues;
                            early_win_q <= (round_cnt_d < C_ROUNDS);
                        end else if (round_cnt_d == C_ROUNDS) begin
                            if (score1_d > score2_d) begin
                                winner_q <= 2'b01;
                            end else if (score2_d > score1_d) begin
                                winner_q <= 2'b10;
                            end else begin
                                winner_q <= 2'b11;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gs_if.score1     = score1_q;
    assign gs_if.score2     = score2_q;
    assign gs_if.round_cnt  = round_cnt_q;
    assign gs_if.busy       = busy_q;
    assign gs_if.done       = done_q;
    assign gs_if.done_pulse = done_pulse_q;
    assign gs_if.winner     = winner_q;
    assign gs_if.early_win  = early_win_q;
endmodule
`default_nettype wire

// File: tb/tb_guess_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_guess_scoreboard
// Brief    : Directed self-checking bench for guess_scoreboard (default build
//            plus a narrow-score, seven-round build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_guess_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    guess_scoreboard_if #(.SW(4)) gs_a ();
    guess_scoreboard_if #(.SW(2)) gs_b ();

    guess_scoreboard #(.ROUNDS(5), .SW(4)) u_dut_a (.clk(clk), .reset(reset), .gs_if(gs_a.slave));
    guess_scoreboard #(.ROUNDS(7), .SW(2)) u_dut_b (.clk(clk), .reset(reset), .gs_if(gs_b.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Full snapshot of DUT A: s1, s2, cnt, busy, done, pulse, winner, early.
    task automatic chk_a(input string tag, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [2:0] cnt, input logic bsy, input logic dn,
                         input logic pls, input logic [1:0] win, input logic ew);
        chk({tag, ".score1"},     8'(gs_a.score1),     8'(s1));
        chk({tag, ".score2"},     8'(gs_a.score2),     8'(s2));
        chk({tag, ".round_cnt"},  8'(gs_a.round_cnt),  8'(cnt));
        chk({tag, ".busy"},       8'(gs_a.busy),       8'(bsy));
        chk({tag, ".done"},       8'(gs_a.done),       8'(dn));
        chk({tag, ".done_pulse"}, 8'(gs_a.done_pulse), 8'(pls));
        chk({tag, ".winner"},     8'(gs_a.winner),     8'(win));
        chk({tag, ".early_win"},  8'(gs_a.early_win),  8'(ew));
    endtask

    task automatic start_a();
        gs_a.start = 1'b1;
        tick();
        gs_a.start = 1'b0;
    endtask

    task automatic round_a(input logic [1:0] cg, input logic [1:0] cp);
        gs_a.round_valid  = 1'b1;
        gs_a.correct_gues = cg;
        gs_a.cr_pair      = cp;
        tick();
        gs_a.round_valid  = 1'b0;
        gs_a.correct_gues = 2'b00;
        gs_a.cr_pair      = 2'b00;
    endtask

    initial begin
        gs_a.start = 1'b0; gs_a.round_valid = 1'b0; gs_a.correct_gues = 2'b00; gs_a.cr_pair = 2'b00;
        gs_b.start = 1'b0; gs_b.round_valid = 1'b0; gs_b.correct_gues = 2'b00; gs_b.cr_pair = 2'b00;

        // Reset values
        tick(); tick();
        reset = 1'b0;
        chk_a("reset", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Stray strobe in IDLE
        round_a(2'b11, 2'b11);
        chk_a("idle_stray", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Five closeness rounds favouring player 1
        start_a();
        chk_a("g1_start", 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) round_a(2'b00, 2'b01);
        chk_a("g1_r4", 4'd4, 4'd0, 3'd4, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        round_a(2'b00, 2'b01);
        chk_a("g1_done", 4'd5, 4'd0, 3'd5, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
        tick();
        chk_a("g1_hold", 4'd5, 4'd0, 3'd5, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);

        // Early exact win by player 2
        start_a();
        chk_a("g2_start", 4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        round_a(2'b00, 2'b11);
        chk_a("g2_r1", 4'd1, 4'd1, 3'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        round_a(2'b10, 2'b00);
        chk_a("g2_done", 4'd1, 4'd3, 3'd2, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);

        // Both exact on round 1
        start_a();
        round_a(2'b11, 2'b00);
        chk_a("g3_done", 4'd2, 4'd2, 3'd1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
        round_a(2'b00, 2'b11);
        chk_a("g3_stray", 4'd2, 4'd2, 3'd1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1);

        // Alternating closeness, idle cycles and ignored start in PLAY
        start_a();
        round_a(2'b00, 2'b01);
        round_a(2'b00, 2'b10);
        gs_a.cr_pair = 2'b11;
        gs_a.start   = 1'b1;
        tick();
        gs_a.start   = 1'b0;
        gs_a.cr_pair = 2'b00;
        chk_a("g4_idlecyc", 4'd1, 4'd1, 3'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        round_a(2'b00, 2'b01);
        round_a(2'b00, 2'b10);
        round_a(2'b00, 2'b01);
        chk_a("g4_done", 4'd3, 4'd2, 3'd5, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
        round_a(2'b01, 2'b11);
        chk_a("g4_stray", 4'd3, 4'd2, 3'd5, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);

        // Exact match on the final round: not an early win
        start_a();
        for (int i = 0; i < 4; i++) round_a(2'b00, 2'b00);
        chk_a("g5_r4", 4'd0, 4'd0, 3'd4, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        round_a(2'b01, 2'b10);
        chk_a("g5_done", 4'd2, 4'd0, 3'd5, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);

        // Tied scores after all rounds
        start_a();
        for (int i = 0; i < 5; i++) round_a(2'b00, 2'b11);
        chk_a("g6_tie", 4'd5, 4'd5, 3'd5, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0);

        // Reset mid-game, together with a strobe
        start_a();
        for (int i = 0; i < 3; i++) round_a(2'b00, 2'b01);
        chk_a("g7_r3", 4'd3, 4'd0, 3'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        reset = 1'b1;
        gs_a.start = 1'b1;
        round_a(2'b01, 2'b11);
        gs_a.start = 1'b0;
        reset = 1'b0;
        chk_a("g7_reset", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        chk_a("g7_after", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Narrow scores: SW=2, ROUNDS=7, saturation at 3
        gs_b.start = 1'b1;
        tick();
        gs_b.start = 1'b0;
        chk("b_start.busy", 8'(gs_b.busy), 8'd1);
        gs_b.round_valid = 1'b1;
        gs_b.cr_pair     = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        chk("b_r6.score1", 8'(gs_b.score1), 8'd3);
        chk("b_r6.round_cnt", 8'(gs_b.round_cnt), 8'd6);
        chk("b_r6.busy", 8'(gs_b.busy), 8'd1);
        tick();
        gs_b.round_valid = 1'b0;
        gs_b.cr_pair     = 2'b00;
        chk("b_done.score1", 8'(gs_b.score1), 8'd3);
        chk("b_done.score2", 8'(gs_b.score2), 8'd0);
        chk("b_done.round_cnt", 8'(gs_b.round_cnt), 8'd7);
        chk("b_done.winner", 8'(gs_b.winner), 8'd1);
        chk("b_done.done", 8'(gs_b.done), 8'd1);
        chk("b_done.done_pulse", 8'(gs_b.done_pulse), 8'd1);
        chk("b_done.early_win", 8'(gs_b.early_win), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
